// File: rtl/instruction_fetch.sv
// Byte-serial instruction fetcher. It reads the opcode byte at eip, decodes the
// instruction length (1, 2 or 5 bytes), collects the remaining bytes one memory
// ack at a time, then presents the assembled instruction until the consumer
// takes it.
module instruction_fetch (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] eip,
    input  logic        start,
    input  logic        flush,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [39:0] instr,
    output logic [3:0]  num_of_ope,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        illegal,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] base_reg;
    logic [2:0]  cnt_reg;
    logic [7:0]  byte_reg [5];
    logic [3:0]  len_reg;
    logic        illegal_reg;

    logic [3:0]  dec_len;
    logic        dec_illegal;
    logic [3:0]  cur_len;
    logic        last_byte;
    logic        accept_start;
    logic        take_byte;

    // Opcode length table; anything unknown is treated as a 1-byte illegal op.
    always_comb begin
        dec_len     = 4'd1;
        dec_illegal = 1'b0;
        case (mem_rdata) inside
            8'h90, 8'hF4, [8'h40:8'h4F]:  dec_len = 4'd1;
            8'h01, 8'h89, 8'h8B, 8'hEB:   dec_len = 4'd2;
            8'h05, [8'hB8:8'hBF], 8'hE9:  dec_len = 4'd5;
            default:                      dec_illegal = 1'b1;
        endcase
    end

    // The length is only known from the opcode byte itself; later bytes use the stored one.
    always_comb begin
        accept_start = (state_reg == ST_IDLE) && start && !flush;
        take_byte    = (state_reg == ST_FETCH) && mem_ack && !flush;
        cur_len      = (cnt_reg == 3'd0) ? dec_len : len_reg;
        last_byte    = (({1'b0, cnt_reg}) + 4'd1) == cur_len;
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept_start)           state_next = ST_FETCH;
            ST_FETCH: if (take_byte && last_byte) state_next = ST_DONE;
            ST_DONE:  if (instr_ready)            state_next = ST_IDLE;
            default:                              state_next = ST_IDLE;
        endcase
        if (flush) begin
            state_next = ST_IDLE;
        end
    end

    // State-decoded handshake outputs.
    always_comb begin
        mem_rd      = (state_reg == ST_FETCH);
        instr_valid = (state_reg == ST_DONE);
        busy        = (state_reg != ST_IDLE);
    end

    // Fetch bookkeeping: base address, byte counter, decoded length and illegal flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base_reg    <= 32'd0;
            cnt_reg     <= 3'd0;
            len_reg     <= 4'd0;
            illegal_reg <= 1'b0;
        end else if (accept_start) begin
            base_reg    <= eip;
            cnt_reg     <= 3'd0;
            illegal_reg <= 1'b0;
        end else if (take_byte) begin
            if (cnt_reg == 3'd0) begin
                len_reg     <= dec_len;
                illegal_reg <= dec_illegal;
            end
            if (!last_byte) begin
                cnt_reg <= cnt_reg + 3'd1;
            end
        end
    end

    // One capture register per instruction byte; bytes not fetched stay cleared.
    for (genvar gi = 0; gi < 5; gi++) begin : g_byte
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                byte_reg[gi] <= 8'd0;
            end else if (accept_start) begin
                byte_reg[gi] <= 8'd0;
            end else if (take_byte && (cnt_reg == 3'(gi))) begin
                byte_reg[gi] <= mem_rdata;
            end
        end
        assign instr[gi*8 +: 8] = byte_reg[gi];
    end

    assign mem_addr   = base_reg + {29'd0, cnt_reg};
    assign num_of_ope = len_reg;
    assign illegal    = illegal_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: table of directed fetches, flush/reset
// corner sequences, then random fetches checked against a reference model.
module tb_instruction_fetch;

    logic        clock;
    logic        reset_n;
    logic [31:0] eip;
    logic        start;
    logic        flush;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [39:0] instr;
    logic [3:0]  num_of_ope;
    logic        instr_valid;
    logic        instr_ready;
    logic        illegal;
    logic        busy;

    int total = 0;
    int bad   = 0;

    instruction_fetch dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .eip         (eip),
        .start       (start),
        .flush       (flush),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .instr       (instr),
        .num_of_ope  (num_of_ope),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .illegal     (illegal),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] eip;
        logic [39:0] bytes;
        int          dly;
        int          hold;
        logic [39:0] exp_instr;
        int          exp_len;
        logic        exp_ill;
    } vec_t;

    vec_t vecs [8];

    logic [7:0] two_ops [4] = '{8'h01, 8'h89, 8'h8B, 8'hEB};
    logic [7:0] misc_ops [4] = '{8'h90, 8'hF4, 8'h05, 8'hE9};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Reference length rule: 0 means "not in the opcode table".
    function automatic int ref_len(input logic [7:0] op);
        if (op == 8'h90 || op == 8'hF4 || op[7:4] == 4'h4) return 1;
        if (op == 8'h01 || op == 8'h89 || op == 8'h8B || op == 8'hEB) return 2;
        if (op == 8'h05 || op == 8'hE9 || (op >= 8'hB8 && op <= 8'hBF)) return 5;
        return 0;
    endfunction

    // Only the first len bytes of the memory image belong to the instruction.
    function automatic logic [39:0] ref_instr(input logic [39:0] bytes, input int len);
        logic [39:0] r;
        r = 40'd0;
        for (int i = 0; i < len; i++) r[8*i +: 8] = bytes[8*i +: 8];
        return r;
    endfunction

    // Runs one fetch starting at a negedge and ends at a negedge. Memory answers
    // each request after dly idle cycles; flush_at >= 0 aborts when that byte is due.
    task automatic fetch_txn(input logic [31:0] a, input logic [39:0] bytes, input int dly,
                             input int flush_at, input int hold, input logic [39:0] exp_instr,
                             input int exp_len, input logic exp_ill);
        int k;
        int w;
        int cyc;
        bit seen;
        logic [31:0] exp_addr;
        eip = a; start = 1'b1; flush = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
        @(negedge clock);
        start = 1'b0;
        eip = $urandom;
        k = 0; w = 0; seen = 0;
        for (cyc = 1; cyc <= 200; cyc++) begin
            mem_ack = 1'b0;
            if (instr_valid) begin
                seen = 1;
                break;
            end
            exp_addr = a + 32'(k);
            check("fetch_mem_rd", mem_rd, 1);
            check("fetch_mem_addr", mem_addr, exp_addr);
            if (k == flush_at) begin
                flush = 1'b1;
                @(negedge clock);
                flush = 1'b0;
                check("flush_busy", busy, 0);
                check("flush_mem_rd", mem_rd, 0);
                check("flush_valid", instr_valid, 0);
                @(negedge clock);
                check("flush_stays_idle", busy, 0);
                $display("txn eip=%08h flushed at byte %0d", a, k);
                return;
            end
            if (w < dly) begin
                w++;
            end else begin
                mem_ack = 1'b1;
                mem_rdata = (k < 5) ? bytes[8*k +: 8] : 8'h00;
                k++;
                w = 0;
            end
            @(negedge clock);
        end
        mem_ack = 1'b0;
        check("valid_seen", seen, 1);
        if (!seen) return;
        check("latency", cyc, exp_len * (dly + 1) + 1);
        check("done_instr", instr, exp_instr);
        check("done_len", num_of_ope, exp_len);
        check("done_illegal", illegal, exp_ill);
        check("done_mem_rd", mem_rd, 0);
        check("done_busy", busy, 1);
        for (int h = 0; h < hold; h++) begin
            start = (h % 2 == 0);
            eip = $urandom;
            @(negedge clock);
            start = 1'b0;
            check("hold_valid", instr_valid, 1);
            check("hold_instr", instr, exp_instr);
            check("hold_len", num_of_ope, exp_len);
            check("hold_illegal", illegal, exp_ill);
            check("hold_mem_rd", mem_rd, 0);
        end
        instr_ready = 1'b1;
        @(negedge clock);
        instr_ready = 1'b0;
        check("release_valid", instr_valid, 0);
        check("release_busy", busy, 0);
        check("len_held_idle", num_of_ope, exp_len);
        $display("txn eip=%08h instr=%010h len=%0d illegal=%0d cycles=%0d",
                 a, instr, num_of_ope, illegal, cyc);
    endtask

    initial begin
        vecs[0] = '{32'h0000000B, 40'hAABBCCDD90, 0, 0, 40'h0000000090, 1, 1'b0};
        vecs[1] = '{32'h00000010, 40'h12345678B8, 0, 0, 40'h12345678B8, 5, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 40'h77665505EB, 0, 0, 40'h00000005EB, 2, 1'b0};
        vecs[3] = '{32'h00000100, 40'h11223344FF, 0, 3, 40'h00000000FF, 1, 1'b1};
        vecs[4] = '{32'h00000200, 40'h0000EEC389, 1, 1, 40'h000000C389, 2, 1'b0};
        vecs[5] = '{32'h00000300, 40'h999999994A, 2, 0, 40'h000000004A, 1, 1'b0};
        vecs[6] = '{32'hFFFFFFFD, 40'h44332211E9, 1, 2, 40'h44332211E9, 5, 1'b0};
        vecs[7] = '{32'h00000400, 40'h5A5A5A5A00, 0, 1, 40'h0000000000, 1, 1'b1};

        eip = 32'd0; start = 1'b0; flush = 1'b0; mem_rdata = 8'd0; mem_ack = 1'b0;
        instr_ready = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check("rst_instr", instr, 0);
        check("rst_len", num_of_ope, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_illegal", illegal, 0);
        check("rst_busy", busy, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            fetch_txn(vecs[i].eip, vecs[i].bytes, vecs[i].dly, -1, vecs[i].hold,
                      vecs[i].exp_instr, vecs[i].exp_len, vecs[i].exp_ill);
        end

        // Slow 5-byte fetch aborted after two bytes, then a clean fetch.
        fetch_txn(32'h00000600, 40'h12345678B8, 2, 2, 0, 40'h12345678B8, 5, 1'b0);
        fetch_txn(32'h00000610, 40'h0000004189, 0, -1, 0, 40'h0000004189, 2, 1'b0);

        // Flush and start together in IDLE: the start is lost.
        eip = 32'h700; start = 1'b1; flush = 1'b1;
        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", busy, 0);
        check("flush_start_mem_rd", mem_rd, 0);
        @(negedge clock);
        check("flush_start_idle", busy, 0);

        // Asynchronous reset between edges during a fetch.
        eip = 32'h00000800; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("pre_rst_busy", busy, 1);
        check("pre_rst_mem_rd", mem_rd, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_mem_rd", mem_rd, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_addr", mem_addr, 0);
        @(negedge clock);
        reset_n = 1'b1;
        fetch_txn(32'h00000900, 40'h00000000F4, 0, -1, 0, 40'h00000000F4, 1, 1'b0);

        // Random fetches against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [39:0] b;
            logic [7:0]  op;
            int          rl;
            int          len;
            int          fa;
            a = ($urandom_range(0, 1) == 1) ? (32'hFFFFFFFF - 32'($urandom_range(0, 4))) : $urandom;
            b = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: op = 8'($urandom);
                1: op = 8'h40 | 8'($urandom_range(0, 15));
                2: op = 8'hB8 + 8'($urandom_range(0, 7));
                3: op = two_ops[$urandom_range(0, 3)];
                default: op = misc_ops[$urandom_range(0, 3)];
            endcase
            b[7:0] = op;
            rl  = ref_len(op);
            len = (rl == 0) ? 1 : rl;
            fa  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : -1;
            fetch_txn(a, b, $urandom_range(0, 2), fa, $urandom_range(0, 3),
                      ref_instr(b, len), len, (rl == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have ports: clock  in  1  single clock, all state on posedge.
REQ-002 SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: eip  in  32  address of next instruction, sampled on start.
REQ-004 SHALL have: start  in  1  begin fetch at eip (honoured only in IDLE).
REQ-005 SHALL have: flush  in  1  synchronous abort of any fetch in progress.
REQ-006 SHALL have: mem_rd  out  1  byte read request; mem_addr  out  32  byte address.
REQ-007 SHALL have: mem_rdata  in  8  read byte; mem_ack  in  1  byte valid this cycle.
REQ-008 SHALL have: instr  out  40  instruction bytes, byte k in bits [8k+7:8k].
REQ-009 SHALL have: num_of_ope  out  4  instruction length in bytes (1, 2 or 5).
REQ-010 SHALL have: instr_valid  out  1; instr_ready  in  1  consumer handshake.
REQ-011 SHALL have: illegal  out  1  opcode not in table; busy  out  1  state != IDLE.

Function
REQ-012 SHALL implement states IDLE, FETCH, DONE.
REQ-013 IDLE & start & !flush SHALL latch base=eip, cnt=0, clear instr to 0, clear illegal, go FETCH.
REQ-014 In FETCH, mem_rd SHALL be 1 and mem_addr SHALL equal base+cnt modulo 2^32; both held stable until mem_ack.
REQ-015 mem_ack SHALL be ignored outside FETCH.
REQ-016 On mem_ack in FETCH, mem_rdata SHALL be written to instr byte cnt.
REQ-017 When cnt==0, length SHALL be decoded from mem_rdata: 0x90, 0xF4, 0x40-0x4F -> 1; 0x01, 0x89, 0x8B, 0xEB -> 2; 0x05, 0xB8-0xBF, 0xE9 -> 5; any other -> 1 with illegal=1.
REQ-018 num_of_ope SHALL be registered with the decoded length on the cnt==0 ack and held until the next start.
REQ-019 On mem_ack, if cnt+1==length, next state SHALL be DONE; else cnt SHALL increment and FETCH continue.
REQ-020 In DONE, instr_valid SHALL be 1 and instr, num_of_ope, illegal SHALL be stable.
REQ-021 DONE & instr_ready SHALL return to IDLE; instr_valid SHALL drop the next cycle.
REQ-022 start SHALL be ignored in FETCH and DONE.
REQ-023 flush SHALL force IDLE next cycle from any state, deasserting mem_rd and instr_valid; the in-flight ack that cycle SHALL be discarded.
REQ-024 flush and start in the same cycle SHALL result in IDLE (flush wins; start lost).
REQ-025 Minimum latency start -> instr_valid SHALL be length+1 cycles (ack every FETCH cycle).
REQ-026 Unfetched bytes of instr SHALL read 0.
REQ-027 mem_rd SHALL be 0 in IDLE and DONE.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, cnt=0, base=0, instr=0, num_of_ope=0, mem_addr=0, mem_rd=0, instr_valid=0, illegal=0, busy=0, independent of clock.
REQ-029 Reset mid-fetch SHALL abandon the fetch; first cycle after release SHALL accept start.

Verification
REQ-030 eip=0x0B, start, mem returns 0x90 with ack immediate -> instr_valid cycle 2, instr=0x0000000090, num_of_ope=1, illegal=0.
REQ-031 eip=0x10, bytes B8 78 56 34 12, ack every cycle -> mem_addr 0x10..0x14, instr=0x12345678B8, num_of_ope=5, valid at cycle 6.
REQ-032 eip=0xFFFFFFFF, bytes EB 05 -> second mem_addr=0x00000000, instr=0x00000005EB, num_of_ope=2.
REQ-033 Opcode 0xFF -> num_of_ope=1, illegal=1, instr=0xFF; hold instr_ready=0 for 3 cycles -> outputs stable, start pulses ignored.
REQ-034 5-byte fetch with ack delayed 2 cycles per byte, flush after byte 2 -> IDLE next cycle, mem_rd=0, no instr_valid; following start fetches correctly.
REQ-035 reset_n low between clock edges during FETCH -> mem_rd and busy drop asynchronously to 0.
